// File: rtl/axi_rd_burst_gen_if.sv
// Request and AR-channel bundle for the read-address burst generator.
// master: the generator side. slave: the requester / AR consumer side.
interface axi_rd_burst_gen_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned ID_MAX_WIDTH = 12,
    parameter int unsigned LEN_WIDTH    = 20
);
    // Request side
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [LEN_WIDTH-1:0]    req_beats;
    logic [ID_MAX_WIDTH-1:0] req_id;
    logic                    busy;
    logic                    done;

    // AR channel
    logic                    arvalid;
    logic                    arready;
    logic [ID_MAX_WIDTH-1:0] arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [3:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arbrust;
    logic [1:0]              arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;

    modport master (
        input  req_valid, req_addr, req_beats, req_id, arready,
        output req_ready, busy, done,
        output arvalid, arid, araddr, arlen, arsize, arbrust, arlock, arcache, arprot, arqos,
        output arregion
    );

    modport slave (
        output req_valid, req_addr, req_beats, req_id, arready,
        input  req_ready, busy, done,
        input  arvalid, arid, araddr, arlen, arsize, arbrust, arlock, arcache, arprot, arqos,
        input  arregion
    );
endinterface

// File: rtl/axi_rd_burst_gen.sv
// AXI read-address burst generator: splits one linear read request into INCR
// bursts of at most 16 beats that never cross a 4 KB boundary.
module axi_rd_burst_gen #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ID_MAX_WIDTH = 12,
    parameter int unsigned LEN_WIDTH    = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_rd_burst_gen_if.master     bus
);
    localparam int unsigned BPB      = DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG = $clog2(BPB);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]    r_rem;
    logic [LEN_WIDTH-1:0]    r_blen;
    logic [ID_MAX_WIDTH-1:0] r_id;
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [3:0]              r_arlen;
    logic [ID_MAX_WIDTH-1:0] r_arid;
    logic                    r_busy;
    logic                    r_done;

    logic [12:0]             w_to4k;
    logic [LEN_WIDTH-1:0]    w_blen;
    logic [LEN_WIDTH-1:0]    w_rem_next;
    logic [ADDR_WIDTH-1:0]   w_step;
    logic [ADDR_WIDTH-1:0]   w_addr_aligned;

    // Beats left before the next 4 KB boundary; address is beat-aligned so the shift is exact
    assign w_to4k         = (13'd4096 - {1'b0, r_addr[11:0]}) >> SIZE_LOG;
    assign w_rem_next     = r_rem - r_blen;
    assign w_step         = ADDR_WIDTH'(r_blen) << SIZE_LOG;
    assign w_addr_aligned = bus.req_addr & ~ADDR_WIDTH'(BPB - 1);

    // Burst length = min(remaining, 16, beats to 4 KB boundary)
    always_comb begin
        w_blen = r_rem;
        if (w_blen > LEN_WIDTH'(16)) begin
            w_blen = LEN_WIDTH'(16);
        end
        if (w_blen > LEN_WIDTH'(w_to4k)) begin
            w_blen = LEN_WIDTH'(w_to4k);
        end
    end

    // Control FSM with registered AR fields, busy and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_blen    <= '0;
            r_id      <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arid    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr <= w_addr_aligned;
                        r_rem  <= bus.req_beats;
                        r_id   <= bus.req_id;
                        if (bus.req_beats == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_blen    <= w_blen;
                    r_araddr  <= r_addr;
                    r_arlen   <= 4'(w_blen - LEN_WIDTH'(1));
                    r_arid    <= r_id;
                    r_arvalid <= 1'b1;
                    r_state   <= ISSUE;
                end
                ISSUE: begin
                    // arvalid is always high here, so arready alone completes the handshake
                    if (bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_addr    <= r_addr + w_step;
                        r_rem     <= w_rem_next;
                        if (w_rem_next == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.arvalid   = r_arvalid;
    assign bus.araddr    = r_araddr;
    assign bus.arlen     = r_arlen;
    assign bus.arid      = r_arid;
    assign bus.arsize    = 3'(SIZE_LOG);
    assign bus.arbrust   = 2'b01;
    assign bus.arlock    = 2'b00;
    assign bus.arcache   = 4'b0011;
    assign bus.arprot    = 3'b000;
    assign bus.arqos     = 4'b0000;
    assign bus.arregion  = 4'b0000;
endmodule

// File: doc/axi_rd_burst_gen.md
Name: axi_rd_burst_gen

Overview:
Read-address burst generator that drives the AXI AR channel master side, upstream of the read-address channel. Accepts one linear read request (start address, beat count, ID) from a DMA/feature-map fetch engine. Splits it into INCR bursts of at most 16 beats that never cross a 4 KB boundary, and issues them in order with full valid/ready handshaking.

Parameters:
ADDR_WIDTH, 32, address width of req_addr and araddr
DATA_WIDTH, 32, AXI data width in bits (power of two, 8..1024); bytes per beat BPB = DATA_WIDTH/8
ID_MAX_WIDTH, 12, width of req_id and arid
LEN_WIDTH, 20, width of req_beats (total beats per request)

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_addr  in  ADDR_WIDTH  start byte address
req_beats  in  LEN_WIDTH  total beats to read
req_id  in  ID_MAX_WIDTH  ID applied to every burst of the request
busy  out  1  request in progress
done  out  1  one-cycle pulse, request fully issued
arvalid  out  1  AR valid
arready  in  1  AR ready
arid  out  ID_MAX_WIDTH  AR ID
araddr  out  ADDR_WIDTH  AR address
arlen  out  4  beats-1
arsize  out  3  log2(BPB), constant
arbrust  out  2  burst type, constant 2'b01 (INCR)
arlock  out  2  constant 0
arcache  out  4  constant 4'b0011
arprot  out  3  constant 0
arqos  out  4  constant 0
arregion  out  4  constant 0

Behaviour:
- One clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values: arvalid=0, araddr=0, arlen=0, arid=0, done=0, busy=0, state=IDLE. Constant outputs are held at the listed values at all times.
- req_ready = (state==IDLE), combinational; high in the reset state once rst_n deasserts.
- FSM states: IDLE, CALC, ISSUE.
- IDLE:
  - On req_valid&&req_ready, latch cur_addr = req_addr with low log2(BPB) bits forced to 0, rem = req_beats, id = req_id.
  - If req_beats==0: done=1 next cycle, stay IDLE, no AR issued.
  - Otherwise go to CALC with busy=1.
- CALC (1 cycle):
  - to4k = (4096 - cur_addr[11:0]) / BPB.
  - blen = min(rem, 16, to4k).
  - Register araddr=cur_addr, arlen=blen-1, arid=id, arvalid=1; go to ISSUE.
- ISSUE:
  - Hold arvalid and all AR fields stable while arready is low (no retraction, no field change).
  - On arvalid&&arready: arvalid=0, cur_addr += blen*BPB (modulo 2^ADDR_WIDTH), rem -= blen.
  - If new rem==0: done=1 for one cycle, busy=0, go to IDLE. Else go to CALC.
- Throughput: at most one AR handshake every 2 cycles.
- First arvalid appears 2 cycles after request acceptance.
- done asserts on the cycle after the final handshake.
- No new request is accepted until done; req_ready=0 while busy.
- busy rises the cycle after acceptance and falls with the done pulse.
- Arithmetic: rem and blen are LEN_WIDTH bits; to4k is 13 bits (max 4096/BPB); no overflow permitted on rem.
- Address wrap past 2^ADDR_WIDTH wraps silently; 0 mod 4096 is a boundary.
- arready high while arvalid is low has no effect.
- Async reset mid-request: arvalid drops immediately, the request is discarded, no done pulse. After release the block is in IDLE with req_ready=1.

Test Plan:
- DATA_WIDTH=32, req_addr=0x1000, req_beats=16 -> one AR: araddr=0x1000, arlen=15, arsize=2, arbrust=01, arid=req_id; done pulses 1 cycle after handshake.
- req_addr=0x0000, req_beats=40, arready tied 1 -> ARs (0x0000,len15), (0x0040,len15), (0x0080,len7), spaced 2 cycles; exactly one done.
- 4 KB split: req_addr=0x0FF0, req_beats=16 -> (0x0FF0,len3) then (0x1000,len11); no burst crosses 0x1000.
- Backpressure: arready low for 5 cycles during first burst of a 40-beat request -> arvalid, araddr, arlen, arid constant across all 5 cycles; req_ready=0, busy=1; sequence unchanged after arready rises.
- req_beats=0, req_addr=0x2000 -> arvalid never asserts; done=1 exactly one cycle after acceptance; req_ready stays 1.
- rst_n pulled low while arvalid=1 in burst 2 of 3 -> arvalid=0 asynchronously, no done; after release req_ready=1 and a new request (0x3000,4 beats) yields one AR (0x3000,len3).
